sl_rx_ctrl: RTL and testbench
=============================

Name: sl_rx_ctrl

Overview:
Host-side controller for one SL serial-line receiver. It sequences configuration writes into the receiver and confirms each one by reading the configuration back. It decodes the receiver's status-change pulses into word and error events, pushes received words into a small FIFO with a valid/ready host interface, and acknowledges each word to the receiver. It sits between the SL receiver and the register/bus layer.

Parameters:
STATUS_WIDTH, 16, width of receiver status bus
CONFIG_WIDTH, 16, width of receiver config bus
FIFO_DEPTH, 4, word FIFO entries, power of two, 2..16
CFG_TIMEOUT, 1023, clk cycles allowed for a config write to take effect

Ports:
clk  in  1  system clock, 16 MHz
rst  in  1  synchronous reset, active-high
rx_status  in  STATUS_WIDTH  receiver status: bit0 WLC, bit1 WRP, bit3 WRF, bit4 PEF, bit5 LEF
rx_data  in  32  receiver buffered word
rx_config  in  CONFIG_WIDTH  receiver config readback
rx_status_changed  in  1  receiver event pulse; status and data are already valid in that cycle
rx_wr_config  out  CONFIG_WIDTH  config value to receiver
rx_wr_enable  out  1  config write enable to receiver
rx_word_picked  out  1  one-cycle pulse that clears receiver WRF
cfg_req  in  1  host config write request, single-cycle pulse
cfg_data  in  CONFIG_WIDTH  requested config
cfg_busy  out  1  config sequence in progress
cfg_done  out  1  one-cycle pulse: config applied
cfg_err  out  1  one-cycle pulse: config rejected or timed out
out_valid  out  1  FIFO head valid
out_ready  in  1  host accepts head
out_data  out  32  FIFO head word
out_pef  out  1  parity flag stored with the head word
fifo_count  out  5  entries held
overflow  out  1  sticky: a word was dropped because the FIFO was full
cnt_clear  in  1  clears overflow and all counters
word_cnt  out  16  words received, wraps
par_err_cnt, len_err_cnt, lev_err_cnt  out  8 each  error counters, saturate at 255

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0 and rx_wr_config=0; FIFO empty; both FSMs go to IDLE. Reset mid-sequence aborts without a done or err pulse.
- Config FSM states: C_IDLE, C_WRITE, C_CHECK.
  - In C_IDLE, a cfg_req latches cfg_data.
  - Validation: bit-quantity field cfg_data[6:1] must be >=8 and bit1 must be 0. On failure, cfg_err pulses one cycle after the req, the FSM stays in C_IDLE, and nothing is written.
  - On success, the FSM moves to C_WRITE: cfg_busy=1, rx_wr_config=latched value, rx_wr_enable=1. It holds there, because the receiver accepts config only between words.
  - Each cycle in C_WRITE, compare rx_config to the latched value. On a match: drop rx_wr_enable, go to C_CHECK for one cycle, pulse cfg_done, return to C_IDLE.
  - Timeout: after CFG_TIMEOUT cycles in C_WRITE, drop rx_wr_enable, pulse cfg_err, return to C_IDLE.
  - cfg_req while cfg_busy=1 is ignored.
- Event decode, in the cycle rx_status_changed=1, priority as listed:
  - LEF=1: lev_err_cnt++.
  - WLC=1: len_err_cnt++.
  - WRF=1 and WRP=0: word event.
  - PEF=1 and WRP=0 and WRF=0: par_err_cnt++.
  - WRP=1 only: start-of-word, ignored.
- Word event:
  - Registered push of {rx_data, PEF} into the FIFO; word_cnt++ (wraps 0xFFFF->0).
  - rx_word_picked pulses exactly one cycle, in the cycle after the event.
  - If the FIFO is full, the word is dropped, overflow is set, and rx_word_picked still pulses.
- FIFO:
  - A pop occurs when out_valid && out_ready. out_data/out_pef show the head combinationally from storage.
  - A push into an empty FIFO gives out_valid=1 the next cycle (latency 1).
  - Simultaneous push and pop: when not empty, fifo_count is unchanged; when full, the pop frees space so the push succeeds and overflow stays 0.
  - Pointers wrap modulo FIFO_DEPTH.
- cnt_clear: takes effect next cycle and wins over a same-cycle increment. It clears counters and overflow, but not the FIFO.
- Counters saturate at 255 and do not wrap.

Test Plan:
- Config accept: cfg_req with cfg_data=0x0041 (32 bits), rx_config follows 3 cycles after rx_wr_enable -> cfg_done pulses once, rx_wr_enable deasserts, cfg_busy low.
- Config reject: cfg_data=0x000B (bit1=1) -> cfg_err one cycle after the req, rx_wr_enable never asserts. With CFG_TIMEOUT=15 and rx_config never matching -> cfg_err after 15 cycles in C_WRITE.
- Word path: event with status=0x0008 and data=0xDEADBEEF -> rx_word_picked pulses the next cycle, out_valid=1, out_data=0xDEADBEEF, out_pef=0, word_cnt=1.
- FIFO full: 5 word events with out_ready=0 and depth 4 -> fifo_count=4, overflow=1, 5 picked pulses. Pop 4 -> words in order, out_valid=0.
- Errors: 300 events with status=0x0020 -> lev_err_cnt=255. Then cnt_clear -> 0. Status 0x0001 -> len_err_cnt=1. Status 0x0010 -> par_err_cnt=1. Status 0x0002 -> no change.
- Reset mid-config: rst during C_WRITE -> next cycle rx_wr_enable=0 and cfg_busy=0, with no done or err pulse.

Source files
------------

// File: rtl/sl_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sl_rx_ctrl
//  Purpose  : Host-side controller for one SL serial-line receiver. Sequences
//             and confirms config writes, decodes status-change events into
//             word / error events, buffers received words in a small FIFO
//             behind a valid/ready interface and keeps event counters.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             rx_status/rx_data/rx_config   - receiver status, word, readback
//             rx_status_changed             - receiver event strobe
//             rx_wr_config/rx_wr_enable     - config write to receiver
//             rx_word_picked                - clears receiver WRF
//             cfg_req/cfg_data              - host config request
//             cfg_busy/cfg_done/cfg_err     - config sequence status
//             out_valid/out_ready/out_data/out_pef - word FIFO head
//             fifo_count/overflow           - FIFO fill level, sticky drop
//             cnt_clear                     - clears counters and overflow
//             word_cnt, par/len/lev_err_cnt - event counters
//  Revision : 1.0 - initial release
// ============================================================================
module sl_rx_ctrl #(
   parameter int STATUS_WIDTH = 16,
   parameter int CONFIG_WIDTH = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int CFG_TIMEOUT  = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STATUS_WIDTH-1:0] rx_status,
   input  logic [31:0]             rx_data,
   input  logic [CONFIG_WIDTH-1:0] rx_config,
   input  logic                    rx_status_changed,
   output logic [CONFIG_WIDTH-1:0] rx_wr_config,
   output logic                    rx_wr_enable,
   output logic                    rx_word_picked,
   input  logic                    cfg_req,
   input  logic [CONFIG_WIDTH-1:0] cfg_data,
   output logic                    cfg_busy,
   output logic                    cfg_done,
   output logic                    cfg_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_data,
   output logic                    out_pef,
   output logic [4:0]              fifo_count,
   output logic                    overflow,
   input  logic                    cnt_clear,
   output logic [15:0]             word_cnt,
   output logic [7:0]              par_err_cnt,
   output logic [7:0]              len_err_cnt,
   output logic [7:0]              lev_err_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TMR_W = $clog2(CFG_TIMEOUT + 1);

   // ------------------------------------------------------------------------
   // Config sequencer
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_WRITE = 2'd1,
      C_CHECK = 2'd2
   } cfg_state_t;

   cfg_state_t       cfg_state;
   logic [TMR_W-1:0] cfg_timer;
   logic             cfg_valid;

   // Bit-quantity field must hold at least 8 and bit1 must be clear.
   assign cfg_valid = (cfg_data[6:1] >= 6'd8) && !cfg_data[1];

   // rx_wr_config doubles as the latched request; it only changes on an
   // accepted request so a rejected one never reaches the receiver.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_state    <= C_IDLE;
         cfg_timer    <= '0;
         rx_wr_config <= '0;
         rx_wr_enable <= 1'b0;
         cfg_busy     <= 1'b0;
         cfg_done     <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
         case (cfg_state)
            C_IDLE: begin
               if (cfg_req) begin
                  if (cfg_valid) begin
                     rx_wr_config <= cfg_data;
                     rx_wr_enable <= 1'b1;
                     cfg_busy     <= 1'b1;
                     cfg_timer    <= '0;
                     cfg_state    <= C_WRITE;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            C_WRITE: begin
               // A readback match wins over a timeout in the same cycle.
               if (rx_config == rx_wr_config) begin
                  rx_wr_enable <= 1'b0;
                  cfg_done     <= 1'b1;
                  cfg_state    <= C_CHECK;
               end else if (cfg_timer == TMR_W'(CFG_TIMEOUT - 1)) begin
                  rx_wr_enable <= 1'b0;
                  cfg_err      <= 1'b1;
                  cfg_busy     <= 1'b0;
                  cfg_state    <= C_IDLE;
               end else begin
                  cfg_timer <= cfg_timer + TMR_W'(1);
               end
            end
            C_CHECK: begin
               cfg_busy  <= 1'b0;
               cfg_state <= C_IDLE;
            end
            default: cfg_state <= C_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Event decode (one event per strobe, highest priority first)
   // ------------------------------------------------------------------------
   logic st_wlc, st_wrp, st_wrf, st_pef, st_lef;
   logic ev_lef, ev_wlc, ev_word, ev_par;
   logic unused_status;

   assign st_wlc = rx_status[0];
   assign st_wrp = rx_status[1];
   assign st_wrf = rx_status[3];
   assign st_pef = rx_status[4];
   assign st_lef = rx_status[5];
   assign unused_status = ^rx_status;

   assign ev_lef  = rx_status_changed && st_lef;
   assign ev_wlc  = rx_status_changed && !st_lef && st_wlc;
   assign ev_word = rx_status_changed && !st_lef && !st_wlc && st_wrf && !st_wrp;
   assign ev_par  = rx_status_changed && !st_lef && !st_wlc && st_pef && !st_wrp && !st_wrf;

   // ------------------------------------------------------------------------
   // Word FIFO and counters
   // ------------------------------------------------------------------------
   logic [32:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [4:0]       count;
   logic             fifo_full, pop, push, drop;

   assign fifo_full = (count == 5'(FIFO_DEPTH));
   assign pop       = out_valid && out_ready;
   // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
   assign push      = ev_word && (!fifo_full || pop);
   assign drop      = ev_word && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         rx_word_picked <= 1'b0;
         overflow       <= 1'b0;
         word_cnt       <= '0;
         par_err_cnt    <= '0;
         len_err_cnt    <= '0;
         lev_err_cnt    <= '0;
      end else begin
         // The receiver is released even when the word is dropped.
         rx_word_picked <= ev_word;
         if (push) begin
            fifo_mem[wr_ptr] <= {rx_data, st_pef};
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase

         if (cnt_clear) begin
            overflow    <= 1'b0;
            word_cnt    <= '0;
            par_err_cnt <= '0;
            len_err_cnt <= '0;
            lev_err_cnt <= '0;
         end else begin
            if (drop)    overflow <= 1'b1;
            if (ev_word) word_cnt <= word_cnt + 16'd1;
            if (ev_par && par_err_cnt != 8'hFF) par_err_cnt <= par_err_cnt + 8'd1;
            if (ev_wlc && len_err_cnt != 8'hFF) len_err_cnt <= len_err_cnt + 8'd1;
            if (ev_lef && lev_err_cnt != 8'hFF) lev_err_cnt <= lev_err_cnt + 8'd1;
         end
      end
   end

   assign out_valid  = (count != 5'd0);
   assign out_data   = fifo_mem[rd_ptr][32:1];
   assign out_pef    = fifo_mem[rd_ptr][0];
   assign fifo_count = count;

endmodule
`default_nettype wire

// File: tb/tb_sl_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sl_rx_ctrl
//  Purpose  : Self-checking bench for sl_rx_ctrl. A queue-based model of the
//             word path and counters is compared every cycle; the config
//             sequencer is exercised with directed, hand-timed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sl_rx_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] rx_status;
   logic [31:0] rx_data;
   logic [15:0] rx_config;
   logic        rx_status_changed;
   logic [15:0] rx_wr_config;
   logic        rx_wr_enable;
   logic        rx_word_picked;
   logic        cfg_req;
   logic [15:0] cfg_data;
   logic        cfg_busy, cfg_done, cfg_err;
   logic        out_valid, out_ready, out_pef;
   logic [31:0] out_data;
   logic [4:0]  fifo_count;
   logic        overflow, cnt_clear;
   logic [15:0] word_cnt;
   logic [7:0]  par_err_cnt, len_err_cnt, lev_err_cnt;

   int total = 0;
   int bad   = 0;

   sl_rx_ctrl #(
      .STATUS_WIDTH(16), .CONFIG_WIDTH(16), .FIFO_DEPTH(DEPTH), .CFG_TIMEOUT(15)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_status(rx_status), .rx_data(rx_data), .rx_config(rx_config),
      .rx_status_changed(rx_status_changed),
      .rx_wr_config(rx_wr_config), .rx_wr_enable(rx_wr_enable),
      .rx_word_picked(rx_word_picked),
      .cfg_req(cfg_req), .cfg_data(cfg_data),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_pef(out_pef), .fifo_count(fifo_count), .overflow(overflow),
      .cnt_clear(cnt_clear), .word_cnt(word_cnt),
      .par_err_cnt(par_err_cnt), .len_err_cnt(len_err_cnt), .lev_err_cnt(lev_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // ------------------------------------------------------------------------
   // Reference model: word queue plus plain integer counters
   // ------------------------------------------------------------------------
   logic [32:0] mq[$];
   int m_words, m_par, m_len, m_lev;
   bit m_ovf, m_picked;

   // 0 none, 1 level err, 2 length err, 3 word, 4 parity err
   function automatic int kind_of(input logic [15:0] s);
      if (s[5]) return 1;
      if (s[0]) return 2;
      if (s[3] && !s[1]) return 3;
      if (s[4] && !s[1] && !s[3]) return 4;
      return 0;
   endfunction

   always @(posedge clk) begin
      int k;
      k = rx_status_changed ? kind_of(rx_status) : 0;
      if (rst) begin
         mq.delete();
         m_words = 0; m_par = 0; m_len = 0; m_lev = 0;
         m_ovf = 0; m_picked = 0;
      end else begin
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         m_picked = (k == 3);
         if (k == 3) begin
            if (mq.size() < DEPTH) mq.push_back({rx_data, rx_status[4]});
            else m_ovf = 1;
         end
         if (k == 3) m_words = (m_words + 1) % 65536;
         if (k == 1 && m_lev < 255) m_lev++;
         if (k == 2 && m_len < 255) m_len++;
         if (k == 4 && m_par < 255) m_par++;
         if (cnt_clear) begin
            m_words = 0; m_par = 0; m_len = 0; m_lev = 0; m_ovf = 0;
         end
      end
      #1;
      chk("m_valid", out_valid, mq.size() != 0);
      chk("m_count", fifo_count, mq.size());
      if (mq.size() != 0) begin
         chk("m_data", out_data, mq[0][32:1]);
         chk("m_pef", out_pef, mq[0][0]);
      end
      chk("m_picked", rx_word_picked, m_picked);
      chk("m_overflow", overflow, m_ovf);
      chk("m_word_cnt", word_cnt, m_words);
      chk("m_par_cnt", par_err_cnt, m_par);
      chk("m_len_cnt", len_err_cnt, m_len);
      chk("m_lev_cnt", lev_err_cnt, m_lev);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic send_event(input logic [15:0] st, input logic [31:0] d);
      rx_status = st; rx_data = d; rx_status_changed = 1'b1;
      tick();
      rx_status_changed = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------------
   initial begin
      int n;
      bit seen_done;
      rst = 1'b1; rx_status = '0; rx_data = '0; rx_config = '0;
      rx_status_changed = 1'b0; cfg_req = 1'b0; cfg_data = '0;
      out_ready = 1'b0; cnt_clear = 1'b0;
      repeat (3) tick();
      chk("rst_busy", cfg_busy, 0);
      chk("rst_wr_en", rx_wr_enable, 0);
      chk("rst_wr_cfg", rx_wr_config, 0);
      chk("rst_done_err", {cfg_done, cfg_err}, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_valid", out_valid, 0);
      rst = 1'b0;
      tick();

      // Config accept, receiver readback follows 3 cycles later
      cfg_req = 1'b1; cfg_data = 16'h0041;
      tick();
      cfg_req = 1'b0;
      chk("acc_busy", cfg_busy, 1);
      chk("acc_wr_en", rx_wr_enable, 1);
      chk("acc_wr_cfg", rx_wr_config, 16'h0041);
      repeat (3) tick();
      chk("acc_wr_en_hold", rx_wr_enable, 1);
      chk("acc_no_done_yet", cfg_done, 0);
      rx_config = 16'h0041;
      tick();
      chk("acc_done", cfg_done, 1);
      chk("acc_wr_en_off", rx_wr_enable, 0);
      tick();
      chk("acc_done_once", cfg_done, 0);
      chk("acc_busy_off", cfg_busy, 0);
      chk("acc_no_err", cfg_err, 0);

      // Config reject: bit1 set, then quantity below 8
      cfg_req = 1'b1; cfg_data = 16'h000B;
      tick();
      cfg_req = 1'b0;
      chk("rej_err", cfg_err, 1);
      chk("rej_wr_en", rx_wr_enable, 0);
      chk("rej_wr_cfg", rx_wr_config, 16'h0041);
      tick();
      chk("rej_err_once", cfg_err, 0);
      cfg_req = 1'b1; cfg_data = 16'h000C;
      tick();
      cfg_req = 1'b0;
      chk("rej_small_err", cfg_err, 1);
      chk("rej_small_busy", cfg_busy, 0);

      // Timeout at the minimum legal quantity; a request while busy is ignored
      tick();
      cfg_req = 1'b1; cfg_data = 16'h0010;
      tick();
      cfg_req = 1'b0;
      n = 0; seen_done = 0;
      while (rx_wr_enable && n < 100) begin
         n++;
         if (n == 2) begin cfg_req = 1'b1; cfg_data = 16'h0041; end
         else cfg_req = 1'b0;
         if (cfg_done) seen_done = 1;
         tick();
      end
      cfg_req = 1'b0;
      chk("to_cycles", n, 15);
      chk("to_err", cfg_err, 1);
      chk("to_busy", cfg_busy, 0);
      chk("to_wr_cfg", rx_wr_config, 16'h0010);
      chk("to_no_done", seen_done, 0);
      tick();

      // Reset during C_WRITE aborts silently
      rx_config = 16'h0000;
      cfg_req = 1'b1; cfg_data = 16'h0041;
      tick();
      cfg_req = 1'b0;
      chk("rmid_wr_en", rx_wr_enable, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rmid_wr_en_off", rx_wr_enable, 0);
      chk("rmid_busy_off", cfg_busy, 0);
      chk("rmid_no_pulse", {cfg_done, cfg_err}, 0);
      tick();
      chk("rmid_no_pulse2", {cfg_done, cfg_err}, 0);

      // Word path
      send_event(16'h0008, 32'hDEADBEEF);
      chk("w_picked", rx_word_picked, 1);
      chk("w_valid", out_valid, 1);
      chk("w_data", out_data, 32'hDEADBEEF);
      chk("w_pef", out_pef, 0);
      chk("w_cnt", word_cnt, 1);
      tick();
      chk("w_picked_once", rx_word_picked, 0);
      send_event(16'h0018, 32'h12345678);
      chk("w2_pef", out_pef, 0);
      out_ready = 1'b1;
      tick();
      chk("w2_head_data", out_data, 32'h12345678);
      chk("w2_head_pef", out_pef, 1);
      tick();
      out_ready = 1'b0;
      chk("w_drained", out_valid, 0);

      // FIFO full: 5 back-to-back words, 5th dropped
      for (int i = 0; i < 5; i++) begin
         send_event(16'h0008, 32'h10000000 + i);
         chk("full_picked", rx_word_picked, 1);
      end
      chk("full_count", fifo_count, 4);
      chk("full_ovf", overflow, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("full_order", out_data, 32'h10000000 + i);
         tick();
      end
      out_ready = 1'b0;
      chk("full_empty", out_valid, 0);

      // Clear, refill, then push while popping at full
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      chk("clr_ovf", overflow, 0);
      chk("clr_words", word_cnt, 0);
      for (int i = 0; i < 4; i++) send_event(16'h0008, 32'hA0 + i);
      out_ready = 1'b1;
      send_event(16'h0008, 32'hA4);
      out_ready = 1'b0;
      chk("pp_count", fifo_count, 4);
      chk("pp_ovf", overflow, 0);
      chk("pp_head", out_data, 32'hA1);
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      chk("pp_empty", out_valid, 0);

      // Error counters: saturation, clear priority, decode priority
      rx_status = 16'h0020; rx_data = '0; rx_status_changed = 1'b1;
      repeat (300) tick();
      rx_status_changed = 1'b0;
      chk("lev_sat", lev_err_cnt, 255);
      cnt_clear = 1'b1; rx_status_changed = 1'b1;
      tick();
      cnt_clear = 1'b0; rx_status_changed = 1'b0;
      chk("lev_clear_wins", lev_err_cnt, 0);
      send_event(16'h0001, 32'h0);
      chk("len_one", len_err_cnt, 1);
      send_event(16'h0010, 32'h0);
      chk("par_one", par_err_cnt, 1);
      send_event(16'h0002, 32'h0);
      chk("wrp_ignored", {par_err_cnt, len_err_cnt, lev_err_cnt}, 24'h010100);
      chk("wrp_no_word", fifo_count, 0);
      send_event(16'h0029, 32'h55);
      chk("prio_lev", lev_err_cnt, 1);
      chk("prio_no_word", rx_word_picked, 0);
      send_event(16'h000A, 32'h66);
      chk("wrp_wrf_no_word", fifo_count, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
